spi_temp_ctrl: RTL and testbench
================================

# spi_temp_ctrl

SPI master sequencer for the temperature sensor front end. It runs one read-only 24-bit SPI frame (mode 0, MSB first) from the sensor, either on a single-cycle request or periodically. It then presents the captured word to `SPI_register` through `reg_d_in` and a one-cycle `reg_load` strobe. It owns the sensor bus (`sclk`, `cs_n`, `miso`) and schedules all register updates.

## Interface
Parameters:
- `CLK_DIV`, default 4: system clocks per SCLK half-period; must be at least 1.
- `SAMPLE_PERIOD`, default 1000: clocks between automatic frame triggers; must be at least 2.
- `CS_GUARD`, default 2: clocks `cs_n` is held low before the first SCLK edge and after the last one; must be at least 1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; all state returns to reset values immediately.
- `start`  in  1  single-cycle frame request.
- `auto_en`  in  1  enables periodic triggering.
- `clr_ovr`  in  1  clears `overrun`.
- `miso`  in  1  sensor serial data.
- `sclk`  out  1  SPI clock; idles low; reset 0.
- `cs_n`  out  1  chip select, active low; reset 1.
- `reg_d_in`  out  24  last complete frame, driven to `SPI_register.d_in`; reset 0.
- `reg_load`  out  1  one-cycle strobe, high when `reg_d_in` has just been updated; reset 0.
- `busy`  out  1  high in every state except IDLE; reset 0.
- `overrun`  out  1  sticky flag for a dropped trigger; reset 0.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE. Reset state is IDLE.
- A trigger is either `start`=1 or an automatic tick.
- **IDLE:** on a trigger, go to SETUP. `cs_n` drops on the next edge.
- **SETUP:** `cs_n`=0, `sclk`=0 for `CS_GUARD` clocks, then go to SHIFT.
- **SHIFT:** 24 bits, each `2*CLK_DIV` clocks long.
  - `sclk` is low for `CLK_DIV` clocks, then high for `CLK_DIV` clocks.
  - `miso` is sampled into a 24-bit shift register on the clock where `sclk` goes high (left shift, MSB first).
  - After the 24th high phase, `sclk` returns low and the FSM goes to HOLD.
- **HOLD:** `cs_n`=0, `sclk`=0 for `CS_GUARD` clocks, then go to DONE.
- **DONE:** one clock.
  - `cs_n`=1.
  - `reg_d_in` is loaded from the shift register; it is held until the next DONE.
  - `reg_load`=1 for this clock only.
  - Next state is IDLE.
- Bit counter: 5 bits, 0..23.
- Half-period counter: `$clog2(CLK_DIV)` bits, wide enough for `CLK_DIV`-1; reloaded at every `sclk` toggle.
- Period counter:
  - Counts 0..`SAMPLE_PERIOD`-1 while `auto_en`=1, then wraps to 0.
  - The automatic tick is the cycle the counter equals `SAMPLE_PERIOD`-1.
  - Counts regardless of FSM state.
  - Held at 0 while `auto_en`=0.
- Boundary rules:
  - **Trigger while busy:** the trigger is dropped and `overrun` is set on the next edge. The current frame is not disturbed.
  - **`start` and automatic tick together in IDLE:** exactly one frame starts; no overrun.
  - **`start` and tick together while busy:** `overrun` is set once.
  - **`clr_ovr` together with a new overrun event:** the set wins.
  - **`auto_en` falling mid-frame:** the frame completes normally; the period counter is cleared.
  - **Trigger in the DONE cycle:** counts as busy and sets `overrun`. A trigger in the first IDLE cycle after DONE is accepted.
  - **Reset mid-frame:** `cs_n`=1 and `sclk`=0 immediately. Partial data is discarded and `reg_d_in` is cleared to 0. No `reg_load` is produced.

## Timing
- Trigger sampled at edge T:
  - `cs_n` falls at T+1.
  - First `sclk` rise at T+1+`CS_GUARD`+`CLK_DIV`.
  - `reg_load` high during cycle T+L.
  - L = 1 + 2·`CS_GUARD` + 48·`CLK_DIV` = 197 with defaults.
- `cs_n` rises in the same cycle `reg_load` is high.
- `busy` is high from T+1 through T+L inclusive.
- Earliest next frame start: trigger at T+L+1.
- `reg_d_in` is stable except at the DONE edge.
- All outputs are registered; there are no combinational paths from input to output.
- SCLK frequency = f_clk / (2·`CLK_DIV`).

## Test plan
- **Reset values:** assert `reset` for 20 ns. Check `sclk`=0, `cs_n`=1, `reg_d_in`=0, `reg_load`=0, `busy`=0, `overrun`=0.
- **Single frame:** defaults; pulse `start`; sensor model drives 24'h000064 MSB first, changing on `sclk` falling edges. Check `reg_d_in`=24'h000064, `reg_load` high for exactly 1 cycle, 197 cycles after `start`. Check exactly 24 `sclk` rising edges.
- **Auto mode:** `SAMPLE_PERIOD`=300, `auto_en`=1, sensor returns 24'h000044. Check `reg_load` pulses exactly 300 cycles apart, each with `reg_d_in`=24'h000044, and `overrun` stays 0.
- **Overrun:** pulse `start` at cycle 0 and again at cycle 50. Check exactly one frame runs and `overrun`=1 from cycle 51. Pulse `clr_ovr` and check `overrun`=0.
- **Reset mid-frame:** assert `reset` 100 cycles into a frame with data 24'hFFFFFF. Check `cs_n`=1 and `sclk`=0 immediately, no `reg_load`, and `reg_d_in`=0. A later `start` with 24'hA5A5A5 yields `reg_d_in`=24'hA5A5A5.
- **Simultaneous triggers:** `start` pulse coincides with the automatic tick in IDLE. Check exactly one frame runs and `overrun`=0.

Source files
------------

// File: rtl/spi_temp_ctrl.sv
// SPI master sequencer for the temperature sensor: runs one read-only 24-bit
// mode-0 frame on request or periodically, then strobes the word into SPI_register.
module spi_temp_ctrl #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int CS_GUARD      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        auto_en,
    input  logic        clr_ovr,
    input  logic        miso,
    output logic        sclk,
    output logic        cs_n,
    output logic [23:0] reg_d_in,
    output logic        reg_load,
    output logic        busy,
    output logic        overrun
);
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (CS_GUARD > 1) ? $clog2(CS_GUARD) : 1;
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam logic [HW-1:0] HALF_MAX   = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GUARD_MAX  = GW'(CS_GUARD - 1);
    localparam logic [PW-1:0] PERIOD_MAX = PW'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t          state, state_next;
    logic [HW-1:0]   half_cnt;
    logic [GW-1:0]   guard_cnt;
    logic [4:0]      bit_cnt;
    logic [PW-1:0]   period_cnt;
    logic [23:0]     shreg;
    logic            tick, trigger, half_tick;

    assign tick      = auto_en && (period_cnt == PERIOD_MAX);
    assign trigger   = start || tick;
    assign half_tick = (state == SHIFT) && (half_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = SETUP;
            SETUP:   if (guard_cnt == '0) state_next = SHIFT;
            SHIFT:   if (half_tick && sclk && (bit_cnt == 5'd23)) state_next = HOLD;
            HOLD:    if (guard_cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so every port is a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            half_cnt   <= '0;
            guard_cnt  <= '0;
            bit_cnt    <= '0;
            period_cnt <= '0;
            shreg      <= '0;
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            reg_d_in   <= '0;
            reg_load   <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if ((state_next != state) && (state_next == SETUP || state_next == HOLD))
                guard_cnt <= GUARD_MAX;
            else if ((state == SETUP || state == HOLD) && guard_cnt != '0)
                guard_cnt <= guard_cnt - GW'(1);

            if (state != SHIFT || half_cnt == '0) half_cnt <= HALF_MAX;
            else                                  half_cnt <= half_cnt - HW'(1);

            if (half_tick) sclk <= ~sclk;

            // Sample on the low-to-high transition; count bits on the fall.
            if (half_tick && !sclk) shreg <= {shreg[22:0], miso};

            if (state != SHIFT)                             bit_cnt <= '0;
            else if (half_tick && sclk && bit_cnt != 5'd23) bit_cnt <= bit_cnt + 5'd1;

            if (!auto_en || period_cnt == PERIOD_MAX) period_cnt <= '0;
            else                                      period_cnt <= period_cnt + PW'(1);

            cs_n     <= !(state_next == SETUP || state_next == SHIFT || state_next == HOLD);
            busy     <= (state_next != IDLE);
            reg_load <= (state_next == DONE);
            if (state_next == DONE) reg_d_in <= shreg;

            if (trigger && state != IDLE) overrun <= 1'b1;
            else if (clr_ovr)             overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_temp_ctrl.sv
// Self-checking bench for spi_temp_ctrl: table of single frames plus
// hand-written overrun, reset, auto and simultaneous-trigger sequences.
module tb_spi_temp_ctrl;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, auto_en = 1'b0, clr_ovr = 1'b0, miso = 1'b0;
    logic        sclk, cs_n, reg_load, busy, overrun;
    logic [23:0] reg_d_in;
    int          n_checks = 0, n_fail = 0;
    logic [23:0] sens_word = '0;
    int          sens_idx = 0;

    always #5 clk = ~clk;

    spi_temp_ctrl #(.CLK_DIV(4), .SAMPLE_PERIOD(300), .CS_GUARD(2)) dut (
        .clk(clk), .reset(reset), .start(start), .auto_en(auto_en), .clr_ovr(clr_ovr),
        .miso(miso), .sclk(sclk), .cs_n(cs_n), .reg_d_in(reg_d_in), .reg_load(reg_load),
        .busy(busy), .overrun(overrun)
    );

    // Sensor model: MSB presented at cs_n fall, next bit after each sclk fall.
    always @(negedge cs_n) begin
        sens_idx = 23;
        miso = sens_word[sens_idx];
    end
    always @(negedge sclk) begin
        if (!cs_n && sens_idx > 0) begin
            sens_idx = sens_idx - 1;
            miso = sens_word[sens_idx];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic [23:0] word, output int load_cnt, output int load_at,
                             output logic [23:0] cap, output int first_rise, output int rises,
                             output int busy_err, output int csn_err);
        logic prev_sclk;
        sens_word = word;
        load_cnt = 0; load_at = -1; cap = '0; first_rise = -1; rises = 0;
        busy_err = 0; csn_err = 0; prev_sclk = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (reg_load) begin load_cnt++; load_at = k; cap = reg_d_in; end
            if (sclk && !prev_sclk) begin rises++; if (first_rise < 0) first_rise = k; end
            prev_sclk = sclk;
            if (busy !== (k <= 197)) busy_err++;
            if (cs_n !== (k >= 197)) csn_err++;
        end
    endtask

    typedef struct {
        logic [23:0] word;
        logic [23:0] exp_word;
        int          exp_load_at;
        int          exp_rises;
    } frame_vec_t;

    frame_vec_t vecs[6];

    initial begin
        int          lc, la, fr, rs, be, ce, ov_err;
        logic [23:0] cap;
        int          ld_t[4];

        vecs[0] = '{24'h000064, 24'h000064, 197, 24};
        vecs[1] = '{24'hA5A5A5, 24'hA5A5A5, 197, 24};
        vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 197, 24};
        vecs[3] = '{24'h000000, 24'h000000, 197, 24};
        vecs[4] = '{24'h800001, 24'h800001, 197, 24};
        vecs[5] = '{24'h5A3C96, 24'h5A3C96, 197, 24};

        // Reset values
        #20;
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_reg_d_in", 32'(reg_d_in), 32'd0);
        chk("rst_reg_load", 32'(reg_load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].word, lc, la, cap, fr, rs, be, ce);
            chk("frame_data", 32'(cap), 32'(vecs[i].exp_word));
            chk("frame_load_cnt", lc, 32'd1);
            chk("frame_load_at", la, vecs[i].exp_load_at);
            chk("frame_sclk_rises", rs, vecs[i].exp_rises);
            chk("frame_first_rise", fr, 32'd7);
            chk("frame_busy_profile", be, 32'd0);
            chk("frame_cs_n_profile", ce, 32'd0);
            chk("frame_reg_d_in_held", 32'(reg_d_in), 32'(vecs[i].exp_word));
            chk("frame_overrun", 32'(overrun), 32'd0);
        end

        // Overrun: second start at cycle 50 is dropped
        sens_word = 24'h123456; lc = 0; la = -1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (reg_load) begin lc++; la = k; end
            if (k == 50) chk("ovr_before", 32'(overrun), 32'd0);
            if (k == 51) chk("ovr_set", 32'(overrun), 32'd1);
            start = (k == 50);
        end
        chk("ovr_load_cnt", lc, 32'd1);
        chk("ovr_load_at", la, 32'd197);
        chk("ovr_data", 32'(reg_d_in), 32'h123456);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Set beats clear; trigger in DONE overruns; trigger right after DONE is accepted
        sens_word = 24'h0F0F0F; lc = 0; ld_t[0] = -1; ld_t[1] = -1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 450; k++) begin
            @(negedge clk);
            if (reg_load) begin
                if (lc < 2) ld_t[lc] = k;
                lc++;
            end
            if (k == 21)  chk("set_wins_over_clr", 32'(overrun), 32'd1);
            if (k == 31)  chk("clr_alone", 32'(overrun), 32'd0);
            if (k == 198) chk("done_trigger_ovr", 32'(overrun), 32'd1);
            start   = (k == 20) || (k == 197) || (k == 198);
            clr_ovr = (k == 20) || (k == 30);
        end
        chk("done_seq_load_cnt", lc, 32'd2);
        chk("done_seq_load1", ld_t[0], 32'd197);
        chk("done_seq_load2", ld_t[1], 32'd395);
        chk("done_seq_data", 32'(reg_d_in), 32'h0F0F0F);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;

        // Reset in the middle of a frame
        sens_word = 24'hFFFFFF; lc = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 103; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (reg_load) lc++;
        end
        chk("midrst_pre_cs_n", 32'(cs_n), 32'd0);
        chk("midrst_pre_sclk", 32'(sclk), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_cs_n", 32'(cs_n), 32'd1);
        chk("midrst_sclk", 32'(sclk), 32'd0);
        chk("midrst_reg_d_in", 32'(reg_d_in), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (reg_load) lc++;
        end
        chk("midrst_no_load", lc, 32'd0);
        chk("midrst_reg_d_in_after", 32'(reg_d_in), 32'd0);
        run_frame(24'hA5A5A5, lc, la, cap, fr, rs, be, ce);
        chk("post_rst_data", 32'(cap), 32'hA5A5A5);
        chk("post_rst_load_at", la, 32'd197);

        // Auto mode, period 300
        sens_word = 24'h000044; lc = 0; ov_err = 0;
        for (int i = 0; i < 4; i++) ld_t[i] = -1;
        @(negedge clk);
        auto_en = 1'b1;
        for (int k = 1; k <= 1150; k++) begin
            @(negedge clk);
            if (reg_load) begin
                if (lc < 4) ld_t[lc] = k;
                lc++;
                chk("auto_data", 32'(reg_d_in), 32'h000044);
            end
            if (overrun) ov_err++;
        end
        auto_en = 1'b0;
        chk("auto_load_cnt", lc, 32'd3);
        chk("auto_first_load", ld_t[0], 32'd496);
        chk("auto_interval1", ld_t[1] - ld_t[0], 32'd300);
        chk("auto_interval2", ld_t[2] - ld_t[1], 32'd300);
        chk("auto_overrun", ov_err, 32'd0);
        repeat (250) @(negedge clk);

        // start coincides with the tick in IDLE; auto_en drops mid-frame
        sens_word = 24'h3C3C3C; lc = 0; la = -1; ov_err = 0;
        @(negedge clk);
        auto_en = 1'b1;
        for (int k = 1; k <= 900; k++) begin
            @(negedge clk);
            if (reg_load) begin lc++; la = k; end
            if (overrun) ov_err++;
            start = (k == 299);
            if (k == 400) auto_en = 1'b0;
        end
        chk("simul_load_cnt", lc, 32'd1);
        chk("simul_load_at", la, 32'd496);
        chk("simul_overrun", ov_err, 32'd0);
        chk("simul_data", 32'(reg_d_in), 32'h3C3C3C);
        chk("simul_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
